// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Owns the program counter. Fetches one 32-bit instruction at a time from
// instruction memory over a req/ready handshake, holds it in the instruction
// register until the downstream stage retires it, then computes the next PC
// from PC_Select, the ALU zero flag, the branch offset and the jump target.
//
// Optional build macro: IMEM_TIMEOUT_EN
//   defined   : a fetch that waits TIMEOUT_CYCLES REQ cycles without ready
//               sets the sticky fetch_error and parks the unit in HALT.
//   undefined : REQ waits indefinitely; fetch_error is constant 0.
//
// Ports
//   clk, reset       system clock (rising edge), async active-high reset
//   PC_Select[1:0]   00 increment, 01 branch, 10 jump, 11 hold (halt)
//   branch_zero      ALU zero flag, branch taken when 1
//   branch_imm[15:0] signed branch offset in words
//   jump_target[25:0] jump word index
//   stall            downstream not ready, blocks retire
//   imem_req         memory request (high only in REQ)
//   imem_addr        fetch address, always equal to pc
//   imem_ready       memory returns data this cycle
//   imem_rdata[31:0] fetched instruction
//   instr[31:0]      instruction register
//   instr_valid      instr holds a fetched, not yet retired instruction
//   opcode, funct    instr[31:26], instr[5:0]
//   pc               address of instr
//   pc_plus4         pc + 4
//   fetch_error      sticky watchdog error
// -----------------------------------------------------------------------------
// state   | meaning
// --------+-------------------------------------------------------------------
// IDLE    | one cycle after reset release
// REQ     | imem_req high, waiting for imem_ready
// VALID   | instruction held, waiting for retire (stall low)
// HALT    | terminal; left only through reset
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            PC_Select,
  input  logic                  branch_zero,
  input  logic [15:0]           branch_imm,
  input  logic [25:0]           jump_target,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [5:0]            opcode,
  output logic [5:0]            funct,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  fetch_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] branch_off;
  logic [ADDR_WIDTH-1:0] branch_pc;
  logic [ADDR_WIDTH-1:0] jump_pc;
  logic [ADDR_WIDTH-1:0] next_pc;

  // ---------------------------------------------------------------------------
  // Next-PC arithmetic (all modulo 2^ADDR_WIDTH)
  // ---------------------------------------------------------------------------
  assign pc_inc     = pc_q + ADDR_WIDTH'(4);
  // Word offset sign-extended and scaled to bytes.
  assign branch_off = {{(ADDR_WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign branch_pc  = pc_inc + branch_off;

  // Jump keeps the region bits above the 28-bit jump span from pc+4.
  generate
    if (ADDR_WIDTH > 28) begin : g_jump_region
      assign jump_pc = {pc_inc[ADDR_WIDTH-1:28], jump_target, 2'b00};
    end else begin : g_jump_flat
      assign jump_pc = {jump_target, 2'b00};
    end
  endgenerate

  always_comb begin
    next_pc = pc_inc;
    unique case (PC_Select)
      2'b00:   next_pc = pc_inc;
      2'b01:   next_pc = branch_zero ? branch_pc : pc_inc;
      2'b10:   next_pc = jump_pc;
      default: next_pc = pc_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch watchdog
  // ---------------------------------------------------------------------------
`ifdef IMEM_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            fetch_error_q, fetch_error_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q      <= '0;
      fetch_error_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  assign fetch_error = fetch_error_q;
`else
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign fetch_error        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
`ifdef IMEM_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    fetch_error_d = fetch_error_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
`ifdef IMEM_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end

      S_REQ: begin
        if (imem_ready) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_VALID;
        end
`ifdef IMEM_TIMEOUT_EN
        // This edge completes the TIMEOUT_CYCLES-th cycle without ready.
        else if (to_cnt_q == TO_LAST) begin
          fetch_error_d = 1'b1;
          state_d       = S_HALT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      S_VALID: begin
        // While stalled everything, including PC_Select, is ignored.
        if (!stall) begin
          if (PC_Select == 2'b11) begin
            state_d = S_HALT;
          end else begin
            pc_d          = next_pc;
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
`ifdef IMEM_TIMEOUT_EN
            to_cnt_d      = '0;
`endif
          end
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. imem_req is decoded from the state register so that reset
  // removes it immediately, without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  PC_Select;
  logic        branch_zero;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_error;

  instr_fetch_unit #(
    .ADDR_WIDTH    (32),
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PC_Select  (PC_Select),
    .branch_zero(branch_zero),
    .branch_imm (branch_imm),
    .jump_target(jump_target),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .funct      (funct),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_error(fetch_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ref_pc;
  logic [31:0] ref_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, {31'd0, act}, {31'd0, req});
  endtask

  // Reference next-PC rule, computed with plain 32-bit modular arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] sel,
                                             input logic bz, input logic [15:0] imm,
                                             input logic [25:0] tgt);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = cur + 32'd4;
    off = 32'($signed(imm));
    case (sel)
      2'd0:    return p4;
      2'd1:    return bz ? p4 + off * 32'd4 : p4;
      2'd2:    return (p4 & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
      default: return cur;
    endcase
  endfunction

  // Called at a negedge while the DUT is in REQ; leaves at the negedge after capture.
  task automatic fetch(input int delay, input logic [31:0] data);
    exp_t e;
    for (int i = 0; i < delay; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      chk1("req_wait", imem_req, 1'b1);
      chk("addr_stable", imem_addr, ref_pc);
      @(posedge clk);
      @(negedge clk);
    end
    imem_ready = 1'b1;
    imem_rdata = data;
    chk1("req_on_ready", imem_req, 1'b1);
    chk("addr_on_ready", imem_addr, ref_pc);
    e.addr = ref_pc;
    e.word = data;
    exp_q.push_back(e);
    ref_instr = data;
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    chk1("valid_after_fetch", instr_valid, 1'b1);
    chk1("req_drop", imem_req, 1'b0);
  endtask

  // Called at a negedge while the DUT is in VALID.
  task automatic retire(input int nstall, input logic [1:0] sel, input logic bz,
                        input logic [15:0] imm, input logic [25:0] tgt);
    for (int i = 0; i < nstall; i++) begin
      stall       = 1'b1;
      PC_Select   = 2'($urandom);
      branch_zero = 1'($urandom);
      branch_imm  = 16'($urandom);
      jump_target = 26'($urandom);
      imem_ready  = 1'($urandom);
      imem_rdata  = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("stall_pc", pc, ref_pc);
      chk("stall_instr", instr, ref_instr);
      chk1("stall_valid", instr_valid, 1'b1);
      chk1("stall_req", imem_req, 1'b0);
    end
    stall       = 1'b0;
    PC_Select   = sel;
    branch_zero = bz;
    branch_imm  = imm;
    jump_target = tgt;
    imem_ready  = 1'($urandom);
    imem_rdata  = $urandom;
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    if (sel == 2'b11) begin
      chk1("halt_valid", instr_valid, 1'b1);
      chk("halt_pc", pc, ref_pc);
      chk1("halt_req", imem_req, 1'b0);
    end else begin
      ref_pc = model_next(ref_pc, sel, bz, imm, tgt);
      chk1("retire_valid", instr_valid, 1'b0);
      chk1("retire_req", imem_req, 1'b1);
      chk("retire_addr", imem_addr, ref_pc);
    end
  endtask

  // Monitor: every new instruction presented is checked against the scoreboard.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL mon_unexpected: instr %h at pc %h, expected no instruction", instr, pc);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", pc, e.addr);
          chk("mon_instr", instr, e.word);
          chk("mon_opcode", 32'(opcode), 32'(e.word[31:26]));
          chk("mon_funct", 32'(funct), 32'(e.word[5:0]));
          chk("mon_pc_plus4", pc_plus4, e.addr + 32'd4);
        end
      end
      prev_valid = instr_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset       = 1'b1;
    PC_Select   = 2'b00;
    branch_zero = 1'b0;
    branch_imm  = 16'h0;
    jump_target = 26'h0;
    stall       = 1'b0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'h0;
    ref_pc      = 32'h0;
    ref_instr   = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_err", fetch_error, 1'b0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_funct", 32'(funct), 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);

    // First fetch with ready tied high: valid two cycles after release.
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0020;
    @(posedge clk);
    @(negedge clk);
    chk1("lat_valid_c1", instr_valid, 1'b0);
    chk1("lat_req_c1", imem_req, 1'b1);
    chk("lat_addr_c1", imem_addr, 32'h0);
    begin
      exp_t e;
      e.addr = 32'h0;
      e.word = 32'h0000_0020;
      exp_q.push_back(e);
    end
    ref_instr = 32'h0000_0020;
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    chk1("lat_valid_c2", instr_valid, 1'b1);
    chk("lat_opcode", 32'(opcode), 32'h0);
    chk("lat_funct", 32'(funct), 32'h20);

    retire(0, 2'b00, 1'b0, 16'h0, 26'h0);
    chk("inc_pc4", imem_addr, 32'h4);

    fetch(1, $urandom);
    retire(0, 2'b10, 1'b0, 16'h0, 26'h000_0040);
    chk("jump_0x100", imem_addr, 32'h100);

    fetch(0, $urandom);
    retire(2, 2'b01, 1'b1, 16'hFFFE, 26'h0);
    chk("branch_taken_neg", imem_addr, 32'h0FC);

    fetch(2, $urandom);
    retire(0, 2'b10, 1'b0, 16'h0, 26'h000_0040);
    chk("jump_back_0x100", imem_addr, 32'h100);

    fetch(0, $urandom);
    retire(5, 2'b01, 1'b0, 16'hFFFE, 26'h0);
    chk("branch_not_taken", imem_addr, 32'h104);

    fetch(3, $urandom);
    retire(0, 2'b01, 1'b1, 16'hFFBB, 26'h0);
    chk("branch_wrap", imem_addr, 32'hFFFF_FFF4);

    fetch(0, $urandom);
    retire(1, 2'b10, 1'b0, 16'h0, 26'h000_0040);
    chk("jump_region", imem_addr, 32'hF000_0100);

    fetch(0, $urandom);
    retire(0, 2'b10, 1'b0, 16'h0, 26'h3FF_FFFF);
    chk("jump_top", imem_addr, 32'hFFFF_FFFC);

    fetch(1, $urandom);
    retire(0, 2'b00, 1'b0, 16'h0, 26'h0);
    chk("inc_wrap", imem_addr, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      fetch($urandom_range(0, 5), $urandom);
      retire($urandom_range(0, 3), 2'($urandom_range(0, 2)), 1'($urandom),
             16'($urandom), 26'($urandom));
    end

    // Hold: terminal, no further requests.
    fetch(1, $urandom);
    retire(2, 2'b11, 1'b0, 16'h0, 26'h0);
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      stall      = 1'($urandom);
      PC_Select  = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk1("halt_stay_req", imem_req, 1'b0);
      chk1("halt_stay_valid", instr_valid, 1'b1);
      chk("halt_stay_pc", pc, ref_pc);
      chk("halt_stay_instr", instr, ref_instr);
    end
    imem_ready = 1'b0;
    stall      = 1'b0;

    // Reset out of HALT, ready during IDLE is ignored.
    #1 reset = 1'b1;
    #1 chk1("halt_rst_valid", instr_valid, 1'b0);
    chk("halt_rst_pc", pc, 32'h0);
    @(negedge clk);
    reset      = 1'b0;
    ref_pc     = 32'h0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    chk1("idle_ignore_valid", instr_valid, 1'b0);
    chk1("idle_then_req", imem_req, 1'b1);

    // Reset in the second REQ cycle; the late response must be dropped.
    imem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("mid_req_c2", imem_req, 1'b1);
    chk("mid_addr_c2", imem_addr, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk1("async_rst_req", imem_req, 1'b0);
    chk1("async_rst_valid", instr_valid, 1'b0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    @(posedge clk);
    @(negedge clk);
    chk1("late_ready_ignored", instr_valid, 1'b0);
    chk("late_ready_instr", instr, 32'h0);
    reset      = 1'b0;
    imem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    fetch(3, $urandom);
    retire(0, 2'b00, 1'b0, 16'h0, 26'h0);
    chk("post_rst_inc", imem_addr, 32'h4);

`ifdef IMEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      imem_ready = 1'b0;
      chk1("to_req_wait", imem_req, 1'b1);
      chk1("to_err_low", fetch_error, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    chk1("to_err_set", fetch_error, 1'b1);
    chk1("to_req_drop", imem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk1("to_halt_err", fetch_error, 1'b1);
      chk1("to_halt_req", imem_req, 1'b0);
      chk1("to_halt_valid", instr_valid, 1'b0);
    end
    imem_ready = 1'b0;
    #1 reset = 1'b1;
    #1 chk1("to_rst_err", fetch_error, 1'b0);
    @(negedge clk);
    reset = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'b0;
      chk1("no_to_req", imem_req, 1'b1);
      chk1("no_to_err", fetch_error, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    fetch(0, $urandom);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
